// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-block instruction cache with a two-state COMPARE/FETCH miss engine.
// Optional hit/miss counters are compiled in with `define ICACHE_STATS_EN.
module icache_dm #(
    parameter int unsigned SETS = 16,
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    typedef enum logic {COMPARE = 1'b0, FETCH = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [29:0] fetch_addr_q, fetch_addr_d;

    logic             valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS];
    logic [31:0]      data_q  [SETS];

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             tag_match;
    logic             fill_en;
    logic             unused_addr_bits;

    assign req_idx          = imemaddr[IDX_W+1:2];
    assign req_tag          = imemaddr[31:IDX_W+2];
    assign fill_idx         = fetch_addr_q[IDX_W-1:0];
    assign fill_tag         = fetch_addr_q[29:IDX_W];
    assign tag_match        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_addr_bits = ^imemaddr[1:0];

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= COMPARE;
            fetch_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

    // Next-state logic; the miss address is latched so a redirect cannot abort the fill.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        case (state_q)
            COMPARE: begin
                if (imemREN && !tag_match) begin
                    state_d      = FETCH;
                    fetch_addr_d = imemaddr[31:2];
                end
            end
            FETCH: begin
                if (!iwait) state_d = COMPARE;
            end
            default: state_d = COMPARE;
        endcase
    end

    // Output logic
    always_comb begin
        ihit    = 1'b0;
        iREN    = 1'b0;
        fill_en = 1'b0;
        case (state_q)
            COMPARE: ihit = imemREN && tag_match;
            FETCH: begin
                iREN    = 1'b1;
                fill_en = !iwait;
            end
            default: ;
        endcase
    end

    assign iaddr    = {fetch_addr_q, 2'b00};
    assign imemload = data_q[req_idx];

    // Frame storage; data is cleared too so imemload reads zero out of reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(SETS); i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
            tag_q[fill_idx]   <= fill_tag;
            data_q[fill_idx]  <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, miss_count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (ihit) hit_count_q <= hit_count_q + 32'd1;
            if (state_q == COMPARE && state_d == FETCH) miss_count_q <= miss_count_q + 32'd1;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios plus random fetch traffic against a frame-contents model.
module tb_icache_dm;
    localparam int unsigned SETS  = 16;
    localparam int unsigned IDX_W = $clog2(SETS);

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_dm #(.SETS(SETS)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int ren_hi = 0;

    // Model: which word address lives in each frame, plus whether a fill is in flight.
    logic        m_valid [SETS];
    logic [29:0] m_waddr [SETS];
    logic [31:0] m_data  [SETS];
    logic        m_fetching = 1'b0;
    logic [29:0] m_fa = '0;
    logic [31:0] m_hits = '0;
    logic [31:0] m_misses = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(SETS); i++) begin
            m_valid[i] = 1'b0;
            m_waddr[i] = '0;
            m_data[i]  = '0;
        end
        m_fetching = 1'b0;
        m_fa       = '0;
        m_hits     = '0;
        m_misses   = '0;
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model at the edge.
    task automatic cycle(input logic rst, input logic ren, input logic [31:0] addr,
                         input logic wt, input logic [31:0] load,
                         output logic o_hit, output logic o_ren,
                         output logic [31:0] o_iaddr, output logic [31:0] o_load);
        int  idx;
        int  fi;
        logic exp_hit;
        @(negedge CLK);
        RST = rst; imemREN = ren; imemaddr = addr; iwait = wt; iload = load;
        #1;
        idx     = int'((addr >> 2) % SETS);
        exp_hit = !m_fetching && ren && m_valid[idx] && (m_waddr[idx] == addr[31:2]);
        o_hit = ihit; o_ren = iREN; o_iaddr = iaddr; o_load = imemload;
        if (iREN === 1'b1) ren_hi++;
        check("ihit", {31'd0, ihit}, {31'd0, exp_hit});
        check("iREN", {31'd0, iREN}, {31'd0, m_fetching});
        if (m_fetching) check("iaddr", iaddr, {m_fa, 2'b00});
        check("imemload", imemload, m_data[idx]);
`ifdef ICACHE_STATS_EN
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
`endif
        @(posedge CLK);
        if (rst) begin
            model_reset();
        end else if (m_fetching) begin
            if (!wt) begin
                fi = int'(m_fa % SETS);
                m_valid[fi] = 1'b1;
                m_waddr[fi] = m_fa;
                m_data[fi]  = load;
                m_fetching  = 1'b0;
            end
        end else if (ren) begin
            if (exp_hit) m_hits++;
            else begin
                m_fa       = addr[31:2];
                m_fetching = 1'b1;
                m_misses++;
            end
        end
    endtask

    logic        h, r;
    logic [31:0] a, d;

    initial begin
        model_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);

        // Reset state
        cycle(0, 0, 32'h0, 1, 32'h0, h, r, a, d);
        check("rst_ihit", {31'd0, h}, 32'd0);
        check("rst_iren", {31'd0, r}, 32'd0);
        check("rst_iaddr", a, 32'h0);
        check("rst_imemload", d, 32'h0);

        // Cold miss: 3 busy cycles then data
        ren_hi = 0;
        cycle(0, 1, 32'h40, 1, 32'hdead_0000, h, r, a, d);
        check("cold_miss_ihit", {31'd0, h}, 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'h40, 1, 32'hdead_0001, h, r, a, d);
        check("cold_iaddr", a, 32'h40);
        cycle(0, 1, 32'h40, 0, 32'h2001_0005, h, r, a, d);
        cycle(0, 1, 32'h40, 1, 32'h0, h, r, a, d);
        check("cold_ihit", {31'd0, h}, 32'd1);
        check("cold_load", d, 32'h2001_0005);
        check("cold_iren_cycles", ren_hi, 4);

        // Warm hits
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'h40, 1, 32'h0, h, r, a, d);
        check("warm_ihit", {31'd0, h}, 32'd1);
        check("warm_iren", {31'd0, r}, 32'd0);
`ifdef ICACHE_STATS_EN
        #1;
        check("stats_miss", miss_count, 32'd1);
        check("stats_hit", hit_count, 32'd4);
`endif

        // Conflict on index 0
        cycle(0, 1, 32'h80, 1, 32'h0, h, r, a, d);
        check("conf_80_miss", {31'd0, h}, 32'd0);
        cycle(0, 1, 32'h80, 0, 32'h1111_2222, h, r, a, d);
        cycle(0, 1, 32'h80, 1, 32'h0, h, r, a, d);
        check("conf_80_hit", {31'd0, h}, 32'd1);
        cycle(0, 1, 32'h40, 1, 32'h0, h, r, a, d);
        check("conf_40_remiss", {31'd0, h}, 32'd0);
        cycle(0, 1, 32'h40, 0, 32'h2001_0005, h, r, a, d);

        // Redirect mid-fill
        cycle(0, 1, 32'h100, 1, 32'h0, h, r, a, d);
        cycle(0, 1, 32'h200, 1, 32'h0, h, r, a, d);
        check("redir_iaddr", a, 32'h100);
        cycle(0, 1, 32'h200, 0, 32'h0000_1234, h, r, a, d);
        cycle(0, 1, 32'h200, 1, 32'h0, h, r, a, d);
        check("redir_200_miss", {31'd0, h}, 32'd0);
        check("redir_frame_data", d, 32'h0000_1234);
        cycle(0, 1, 32'h200, 0, 32'h0000_5678, h, r, a, d);
        check("redir_200_iren", {31'd0, r}, 32'd1);
        check("redir_200_iaddr", a, 32'h200);

        // Reset in the cycle iwait drops
        cycle(0, 1, 32'h300, 1, 32'h0, h, r, a, d);
        cycle(0, 1, 32'h300, 1, 32'h0, h, r, a, d);
        cycle(1, 1, 32'h300, 0, 32'hbeef_beef, h, r, a, d);
        cycle(0, 1, 32'h300, 1, 32'h0, h, r, a, d);
        check("rstfill_iren", {31'd0, r}, 32'd0);
        check("rstfill_miss", {31'd0, h}, 32'd0);
        cycle(0, 1, 32'h300, 0, 32'h3333_3333, h, r, a, d);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 3) << (IDX_W + 2)) | ($urandom_range(0, SETS - 1) << 2)
               | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) ra = ra | 32'hf000_0000;
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0), ra,
                  ($urandom_range(0, 2) != 0), $urandom, h, r, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
